image_pixel_sequencer: RTL and testbench
========================================

IMAGE_PIXEL_SEQUENCER -- requirements
Module: image_pixel_sequencer

Interface
REQ-001 Parameter IMG_W, default 320, image width in pixels.
REQ-002 Parameter IMG_H, default 240, image height in lines; frame size NUM_PIX = IMG_W*IMG_H (default 76800).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to stream one full frame; sampled only in IDLE.
REQ-006 abort  input  1  synchronous stop; returns to IDLE on the next edge from any state.
REQ-007 mem_addr  output  19  pixel address to the RGB storage; registered.
REQ-008 mem_channel  output  2  plane select to the storage: 01=R, 10=G, 11=B; registered.
REQ-009 mem_data  input  8  storage read data, valid one cycle after addr/channel are presented.
REQ-010 pix_data  output  24  assembled pixel {R[23:16],G[15:8],B[7:0]}.
REQ-011 pix_x  output  9  column of pix_data, 0..IMG_W-1.
REQ-012 pix_y  output  8  line of pix_data, 0..IMG_H-1.
REQ-013 pix_valid  output  1  pix_data/pix_x/pix_y valid.
REQ-014 pix_ready  input  1  downstream accepts pixel when pix_valid&&pix_ready at an edge.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-017 States SHALL be IDLE, RD_R, RD_G, RD_B, CAP, OUT, DONE.
REQ-018 IDLE: start=1 -> RD_R with mem_addr=0, pix_x=0, pix_y=0; start=0 -> stay.
REQ-019 RD_R: mem_channel=01 at mem_addr; next edge -> RD_G, mem_channel=10.
REQ-020 RD_G: capture mem_data into R byte; next edge -> RD_B, mem_channel=11.
REQ-021 RD_B: capture mem_data into G byte; next edge -> CAP.
REQ-022 CAP: capture mem_data into B byte; next edge -> OUT with pix_valid=1.
REQ-023 OUT: pix_valid held with pix_data/pix_x/pix_y stable until pix_ready=1; no memory access issued.
REQ-024 OUT with pix_ready=1 and mem_addr<NUM_PIX-1: mem_addr+1, pix_x+1 (pix_x wraps to 0 at IMG_W-1 with pix_y+1), pix_valid=0, -> RD_R.
REQ-025 OUT with pix_ready=1 and mem_addr==NUM_PIX-1: pix_valid=0 -> DONE.
REQ-026 DONE: frame_done=1 for exactly this one cycle; next edge -> IDLE.
REQ-027 Latency: start sampled at edge k -> pix_valid first high after edge k+4; minimum 5 cycles per pixel with pix_ready tied high.
REQ-028 start while busy SHALL be ignored (no restart, no queuing).
REQ-029 abort=1 in any non-IDLE state -> IDLE next edge, pix_valid=0, frame_done not pulsed; abort has priority over pix_ready and start.
REQ-030 abort and start both high in IDLE -> stay IDLE.
REQ-031 mem_addr SHALL never exceed NUM_PIX-1; no 19-bit wrap occurs.
REQ-032 mem_channel SHALL be 00 in IDLE, OUT, DONE (no plane selected for capture).

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, mem_addr=0, mem_channel=00, pix_data=0, pix_x=0, pix_y=0, pix_valid=0, busy=0, frame_done=0, regardless of clk.
REQ-034 Reset asserted mid-frame SHALL discard the frame; after release the block waits in IDLE for a new start.

Verification
REQ-035 Storage model with R=addr[7:0], G=~addr[7:0], B=addr[15:8]; start, pix_ready=1 -> pixel 0 = 0x00FF00 at edge k+4, pixel 1 = 0x01FE00, pixels 5 cycles apart.
REQ-036 Full frame, pix_ready=1 -> exactly 76800 pixels, last with pix_x=319, pix_y=239, mem_addr=76799; frame_done one pulse; busy low after.
REQ-037 pix_ready low 10 cycles on pixel 3 -> pix_valid and pix_data stable throughout, no mem_channel activity, pixel 4 follows with correct data.
REQ-038 Line wrap: pixel 319 accepted -> next pixel pix_x=0, pix_y=1, mem_addr=320.
REQ-039 abort in RD_G of pixel 10 -> IDLE next edge, no frame_done; new start restarts at mem_addr=0; start pulses while busy have no effect.
REQ-040 rst_n low mid-clock during OUT -> all outputs zero immediately, IDLE after release.

Source files
------------

// File: rtl/image_pixel_sequencer.sv
// Streams one frame of pixels by reading the R, G and B planes of each address in turn
// and presenting the assembled 24-bit pixel with its column/line until downstream accepts it.
module image_pixel_sequencer #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [18:0] mem_addr,
    output logic [1:0]  mem_channel,
    input  logic [7:0]  mem_data,
    output logic [23:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_R = 3'd1;
    localparam logic [2:0] RD_G = 3'd2;
    localparam logic [2:0] RD_B = 3'd3;
    localparam logic [2:0] CAP  = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_R    = 2'b01;
    localparam logic [1:0] CH_G    = 2'b10;
    localparam logic [1:0] CH_B    = 2'b11;

    localparam logic [18:0] LAST_ADDR = 19'(IMG_W * IMG_H - 1);
    localparam logic [8:0]  LAST_X    = 9'(IMG_W - 1);

    logic [2:0] state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_addr    <= '0;
            mem_channel <= CH_NONE;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else if (abort && state != IDLE) begin
            state       <= IDLE;
            mem_channel <= CH_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state       <= RD_R;
                        mem_addr    <= '0;
                        pix_x       <= '0;
                        pix_y       <= '0;
                        mem_channel <= CH_R;
                    end
                end
                RD_R: begin
                    state       <= RD_G;
                    mem_channel <= CH_G;
                end
                // Read data lags the plane select by one cycle, so each byte lands one state late.
                RD_G: begin
                    pix_data[23:16] <= mem_data;
                    state           <= RD_B;
                    mem_channel     <= CH_B;
                end
                RD_B: begin
                    pix_data[15:8] <= mem_data;
                    state          <= CAP;
                    mem_channel    <= CH_NONE;
                end
                CAP: begin
                    pix_data[7:0] <= mem_data;
                    state         <= OUT;
                end
                OUT: begin
                    if (pix_ready) begin
                        if (mem_addr == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            state       <= RD_R;
                            mem_channel <= CH_R;
                            mem_addr    <= mem_addr + 19'd1;
                            if (pix_x == LAST_X) begin
                                pix_x <= '0;
                                pix_y <= pix_y + 8'd1;
                            end else begin
                                pix_x <= pix_x + 9'd1;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign pix_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_image_pixel_sequencer.sv
// Directed bench: cycle table for the first pixels, then stall, line wrap, frame end, abort and reset.
module tb_image_pixel_sequencer;

    localparam int W = 320;
    localparam int H = 3;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [18:0] mem_addr;
    logic [1:0]  mem_channel;
    logic [7:0]  mem_data = 8'h00;
    logic [23:0] pix_data;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    image_pixel_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mem_addr(mem_addr), .mem_channel(mem_channel), .mem_data(mem_data),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Storage: R=addr[7:0], G=~addr[7:0], B=addr[15:8]; unselected plane returns a marker.
    always @(posedge clk) begin
        case (mem_channel)
            2'b01:   mem_data <= mem_addr[7:0];
            2'b10:   mem_data <= ~mem_addr[7:0];
            2'b11:   mem_data <= mem_addr[15:8];
            default: mem_data <= 8'h5A;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int a);
        logic [18:0] ad;
        ad = 19'(a);
        return {ad[7:0], ~ad[7:0], ad[15:8]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pix_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: pix_valid=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic get_pixel(input int a);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            chk("pix_data", 32'(pix_data), 32'(exp_pix(a)));
            chk("pix_x", 32'(pix_x), 32'(a % W));
            chk("pix_y", 32'(pix_y), 32'(a / W));
            chk("mem_addr", 32'(mem_addr), 32'(a));
            pix_ready = 1'b1;
            step();
            pix_ready = 1'b0;
        end
    endtask

    typedef struct {
        logic        st;
        logic        ab;
        logic        rdy;
        logic [1:0]  ch;
        logic        vld;
        logic        bsy;
        logic [18:0] addr;
        logic [23:0] data;
    } vec_t;

    vec_t tbl[12];

    initial begin
        bit ok;
        logic [23:0] held;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 19'd0, 24'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 19'd0, 24'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 19'd0, 24'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 19'd0, 24'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 19'd0, 24'h00FF00};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 19'd1, 24'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 19'd1, 24'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 19'd1, 24'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 19'd1, 24'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 19'd1, 24'h01FE00};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 19'd1, 24'h01FE00};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 19'd2, 24'h0};

        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_ch", 32'(mem_channel), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].st;
            abort = tbl[i].ab;
            pix_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_ch", i), 32'(mem_channel), 32'(tbl[i].ch));
            chk($sformatf("v%0d_valid", i), 32'(pix_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            if (tbl[i].vld)
                chk($sformatf("v%0d_data", i), 32'(pix_data), 32'(tbl[i].data));
        end
        start = 1'b0;
        pix_ready = 1'b0;

        get_pixel(2);

        // Stall pixel 3 for ten cycles: output frozen, no plane selected.
        wait_valid(ok);
        held = pix_data;
        chk("stall_data0", 32'(held), 32'(exp_pix(3)));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(pix_valid), 32'd1);
            chk("stall_data", 32'(pix_data), 32'(exp_pix(3)));
            chk("stall_ch", 32'(mem_channel), 32'd0);
        end
        get_pixel(3);

        for (int a = 4; a < NPIX; a++) begin
            get_pixel(a);
            if (a == W - 1) begin
                wait_valid(ok);
                chk("wrap_x", 32'(pix_x), 32'd0);
                chk("wrap_y", 32'(pix_y), 32'd1);
                chk("wrap_addr", 32'(mem_addr), 32'(W));
            end
        end
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_valid", 32'(pix_valid), 32'd0);
        chk("done_addr", 32'(mem_addr), 32'(NPIX - 1));
        step();
        chk("done_clear", 32'(frame_done), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);

        start = 1'b1;
        abort = 1'b1;
        step();
        chk("start_abort_idle", 32'(busy), 32'd0);
        abort = 1'b0;
        step();
        start = 1'b0;
        chk("restart_addr", 32'(mem_addr), 32'd0);
        chk("restart_ch", 32'(mem_channel), 32'd1);
        for (int a = 0; a < 10; a++) get_pixel(a);
        chk("p10_ch_r", 32'(mem_channel), 32'd1);
        chk("p10_addr", 32'(mem_addr), 32'd10);
        step();
        chk("p10_ch_g", 32'(mem_channel), 32'd2);
        abort = 1'b1;
        pix_ready = 1'b1;
        step();
        abort = 1'b0;
        pix_ready = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ch", 32'(mem_channel), 32'd0);
        chk("abort_valid", 32'(pix_valid), 32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", 32'(frame_done), 32'd0);
            chk("abort_stay_idle", 32'(busy), 32'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_restart_addr", 32'(mem_addr), 32'd0);
        chk("abort_restart_busy", 32'(busy), 32'd1);
        get_pixel(0);
        get_pixel(1);

        // Asynchronous reset while pixel 2 sits in OUT.
        wait_valid(ok);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(mem_addr), 32'd0);
        chk("ar_ch", 32'(mem_channel), 32'd0);
        chk("ar_data", 32'(pix_data), 32'd0);
        chk("ar_x", 32'(pix_x), 32'd0);
        chk("ar_y", 32'(pix_y), 32'd0);
        chk("ar_valid", 32'(pix_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        get_pixel(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
